// File: rtl/vga_scanout.sv
// Frame-buffer scan-out stage for 640x480 VGA: issues frame-buffer reads, overlays test
// patterns and delay-matches syncs/DE to the returned pixel data.
module vga_scanout #(
    parameter int unsigned FB_W         = 320,
    parameter int unsigned FB_H         = 240,
    parameter int unsigned SCALE_SHIFT  = 1,
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned RD_LATENCY   = 2,
    parameter logic [15:0] BORDER_COLOR = 16'h0000
) (
    input  logic              pixel_clk,
    input  logic              rst_n,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              pixel_valid,
    input  logic              vga_hs_in,
    input  logic              vga_vs_in,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    output logic              fb_bank,
    input  logic [15:0]       fb_rd_data,
    input  logic              swap_req,
    output logic              swap_ack,
    input  logic [1:0]        test_mode,
    output logic [4:0]        vga_r,
    output logic [5:0]        vga_g,
    output logic [4:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic              frame_start
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PENDING = 1'b1;

    logic              valid_a_q;
    logic              vs_prev_q;
    logic [1:0]        mode_q;
    logic [0:0]        state_q, state_d;
    logic              swap_d;
    logic              bank_q;
    logic              ack_q;
    logic              fs_q;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [9:0]        fb_x, fb_y;
    logic              in_range;
    logic              vs_fall;
    logic [15:0]       pat_d;

    logic [RD_LATENCY:0] sb_valid_q, sb_hs_q, sb_vs_q, sb_fb_q;
    logic [15:0]         sb_pat_q [RD_LATENCY+1];

    logic [15:0]       rgb_q, rgb_d;
    logic              hs_out_q, vs_out_q, de_q;

    assign fb_x     = pixel_x >> SCALE_SHIFT;
    assign fb_y     = pixel_y >> SCALE_SHIFT;
    assign in_range = (32'(fb_x) < FB_W) && (32'(fb_y) < FB_H);
    assign vs_fall  = vs_prev_q & ~vga_vs_in;

    assign rd_en_d  = valid_a_q && in_range && (mode_q == 2'd0);
    assign addr_d   = rd_en_d ? (ADDR_W'(fb_y) * ADDR_W'(FB_W) + ADDR_W'(fb_x)) : addr_q;

    always_comb begin
        pat_d = BORDER_COLOR;
        case (mode_q)
            2'd1: begin
                if      (pixel_x < 10'd80)  pat_d = 16'hFFFF;
                else if (pixel_x < 10'd160) pat_d = 16'hFFE0;
                else if (pixel_x < 10'd240) pat_d = 16'h07FF;
                else if (pixel_x < 10'd320) pat_d = 16'h07E0;
                else if (pixel_x < 10'd400) pat_d = 16'hF81F;
                else if (pixel_x < 10'd480) pat_d = 16'hF800;
                else if (pixel_x < 10'd560) pat_d = 16'h001F;
                else                        pat_d = 16'h0000;
            end
            2'd2: pat_d = (pixel_x[4:0] == 5'd0 || pixel_y[4:0] == 5'd0) ? 16'hFFFF : 16'h0000;
            default: pat_d = BORDER_COLOR;
        endcase
    end

    // A request in the same cycle as the vsync edge swaps immediately, without passing PENDING.
    always_comb begin
        state_d = state_q;
        swap_d  = 1'b0;
        if (vs_fall && (state_q == S_PENDING || swap_req)) begin
            swap_d  = 1'b1;
            state_d = S_IDLE;
        end else if (swap_req) begin
            state_d = S_PENDING;
        end
    end

    always_comb begin
        rgb_d = '0;
        if (sb_valid_q[RD_LATENCY]) begin
            rgb_d = sb_fb_q[RD_LATENCY] ? fb_rd_data : sb_pat_q[RD_LATENCY];
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_a_q  <= 1'b0;
            vs_prev_q  <= 1'b1;
            mode_q     <= '0;
            state_q    <= S_IDLE;
            bank_q     <= 1'b0;
            ack_q      <= 1'b0;
            fs_q       <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            sb_valid_q <= '0;
            sb_hs_q    <= '1;
            sb_vs_q    <= '1;
            sb_fb_q    <= '0;
            for (int unsigned i = 0; i <= RD_LATENCY; i++) begin
                sb_pat_q[i] <= '0;
            end
            rgb_q      <= '0;
            hs_out_q   <= 1'b1;
            vs_out_q   <= 1'b1;
            de_q       <= 1'b0;
        end else begin
            valid_a_q  <= pixel_valid;
            vs_prev_q  <= vga_vs_in;
            if (vs_fall) begin
                mode_q <= test_mode;
            end
            state_q    <= state_d;
            bank_q     <= bank_q ^ swap_d;
            ack_q      <= swap_d;
            fs_q       <= vs_fall;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            sb_valid_q <= {sb_valid_q[RD_LATENCY-1:0], valid_a_q};
            sb_hs_q    <= {sb_hs_q[RD_LATENCY-1:0], vga_hs_in};
            sb_vs_q    <= {sb_vs_q[RD_LATENCY-1:0], vga_vs_in};
            sb_fb_q    <= {sb_fb_q[RD_LATENCY-1:0], rd_en_d};
            for (int unsigned i = RD_LATENCY; i > 0; i--) begin
                sb_pat_q[i] <= sb_pat_q[i-1];
            end
            sb_pat_q[0] <= pat_d;
            rgb_q      <= rgb_d;
            hs_out_q   <= sb_hs_q[RD_LATENCY];
            vs_out_q   <= sb_vs_q[RD_LATENCY];
            de_q       <= sb_valid_q[RD_LATENCY];
        end
    end

    assign fb_rd_en    = rd_en_q;
    assign fb_rd_addr  = addr_q;
    assign fb_bank     = bank_q;
    assign swap_ack    = ack_q;
    assign frame_start = fs_q;
    assign vga_r       = rgb_q[15:11];
    assign vga_g       = rgb_q[10:5];
    assign vga_b       = rgb_q[4:0];
    assign vga_hs      = hs_out_q;
    assign vga_vs      = vs_out_q;
    assign vga_de      = de_q;

endmodule
